addr_calc_arbiter: RTL and testbench
====================================

// Module: addr_calc_arbiter
// PURPOSE
//  Shares one pipelined address-calculation datapath between two pointer requesters.
//  The datapath computes count = address - (BASE - ptr) + b.
//  Requester 0 and requester 1 each present a pointer with a valid/ready handshake.
//  A round-robin arbiter grants one request per cycle into a 2-stage pipeline.
//  Results leave on one valid/ready port, tagged with the source requester id, and honour backpressure.
// PARAMETERS
//  W     8      width of address, ptr and b
//  BASE  8'h80  base constant; offset = BASE - ptr (W-bit, wraps)
//  CW    16     result width; addr/count arithmetic done zero-extended to CW bits, mod 2^CW
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  address      in   W   shared base address, sampled on the accept edge
//  b            in   W   shared displacement, sampled on the accept edge
//  req0_valid   in   1   requester 0 has a pointer
//  req0_ptr     in   W   requester 0 pointer
//  req0_ready   out  1   requester 0 accepted this cycle (valid&ready at edge = accept)
//  req1_valid   in   1   requester 1 has a pointer
//  req1_ptr     in   W   requester 1 pointer
//  req1_ready   out  1   requester 1 accepted this cycle
//  out_valid    out  1   out_count/out_id hold a result
//  out_count    out  CW  computed count
//  out_id       out  1   source requester of out_count (0 or 1)
//  out_ready    in   1   downstream accepts the result
//  busy         out  1   any pipeline stage valid
// BEHAVIOUR
//  Reset (async, immediate): s1_valid=0, out_valid=0, out_count=0, out_id=0, rr_ptr=0 (req0 favoured), busy=0.
//    Results in flight are discarded. Releasing reset needs no further sequencing.
//  Pipeline:
//    S1 registers offset=BASE-ptr (W bits), address, b and id.
//    S2 (output) registers count = ({0,address} - {0,offset}) + {0,b}, width CW, wraps mod 2^CW.
//  Stall rules:
//    adv2 = s1_valid & (!out_valid | out_ready).
//    can_accept = !s1_valid | adv2.
//  Output handshake:
//    Output is stalled while out_valid & !out_ready. out_count and out_id stay stable while stalled.
//    out_valid clears on handshake unless adv2 loads a new result in the same cycle.
//  Arbitration (combinational from valids, rr_ptr and can_accept):
//    Only one valid: grant it.
//    Both valid: grant requester rr_ptr.
//    reqN_ready = grant_N & can_accept. At most one ready is high per cycle.
//    Granting requester i sets rr_ptr <= ~i. rr_ptr is unchanged when nothing is accepted.
//  Latency and throughput:
//    Accept at edge N -> out_valid high after edge N+1 (2 cycles through the pipeline, with no stall).
//    Throughput is 1 result per cycle under continuous out_ready.
//    Ordering is strictly the acceptance order. No result is lost or duplicated under any stall pattern.
//  Boundaries:
//    ptr=BASE gives offset=0.
//    ptr>BASE gives an offset that wraps in W bits, e.g. ptr=8'h90 -> offset=8'hF0.
//    addr underflow wraps in CW bits.
//    Simultaneous output handshake and new accept is legal, and both complete in that cycle.
//    req valid dropped without ready: nothing happens. A pending request is not required to stay stable.
//    busy = s1_valid | out_valid.
// TESTING
//  T1 Arithmetic, single request:
//    req0 ptr=8'h20, address=8'h10, b=8'h05 -> out_count=16'hFFB5, out_id=0, two cycles after accept.
//  T2 Boundaries:
//    ptr=8'h80, address=8'h90, b=8'h10 -> 16'h00A0.
//    ptr=8'h00, address=8'hFF, b=8'hFF -> 16'h017E.
//  T3 Round-robin, both valid for 6 cycles, out_ready=1:
//    grants are 0,1,0,1,0,1 and out_id follows the same sequence at one result per cycle.
//  T4 Backpressure:
//    out_ready=0 for 4 cycles with both requesters streaming.
//    Exactly 2 accepts happen, then both readys are low.
//    out_count stays stable during the stall. After release, results drain in order with none lost.
//  T5 Reset mid-operation:
//    assert rst_n=0 with both stages valid -> out_valid, busy and readys drop immediately.
//    The first grant after reset goes to req0.
//  T6 Single requester:
//    only req1 valid continuously -> req1_ready held high, out_id=1 every cycle, no bubbles.

Source files
------------

// File: rtl/addr_calc_arbiter.sv
// Round-robin share of a 2-stage count = address - (BASE - ptr) + b datapath between two requesters.
// Accept at edge N gives out_valid after edge N+1; output stall freezes S2, and S1 accepts only if it can move on.
module addr_calc_arbiter #(
  parameter int unsigned      W    = 8,
  parameter logic [W-1:0]     BASE = 8'h80,
  parameter int unsigned      CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  address,
  input  logic [W-1:0]  b,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_ptr,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_ptr,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_count,
  output logic          out_id,
  input  logic          out_ready,
  output logic          busy
);

  typedef struct packed {
    logic [W-1:0] offset;
    logic [W-1:0] address;
    logic [W-1:0] b;
    logic         id;
  } s1_t;

  logic          s1_valid;
  s1_t           s1_q;
  s1_t           s1_d;
  logic          rr_ptr;
  logic          adv2;
  logic          can_accept;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [W-1:0]  sel_ptr;
  logic [CW-1:0] count_d;

  assign adv2       = s1_valid & (~out_valid | out_ready);
  assign can_accept = ~s1_valid | adv2;

  // rr_ptr only breaks ties; a lone requester is always granted.
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1 = req1_valid & (~req0_valid |  rr_ptr);

  // Gated by rst_n so no handshake is advertised while the pipeline is held in reset.
  assign req0_ready = grant0 & can_accept & rst_n;
  assign req1_ready = grant1 & can_accept & rst_n;
  assign accept     = req0_ready | req1_ready;

  assign sel_ptr        = req1_ready ? req1_ptr : req0_ptr;
  assign s1_d.offset    = BASE - sel_ptr;
  assign s1_d.address   = address;
  assign s1_d.b         = b;
  assign s1_d.id        = req1_ready;

  assign count_d = CW'(s1_q.address) - CW'(s1_q.offset) + CW'(s1_q.b);
  assign busy    = s1_valid | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      rr_ptr   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
      rr_ptr   <= ~s1_d.id;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_id    <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out_count <= count_d;
      out_id    <= s1_q.id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addr_calc_arbiter.sv
// Directed bench for addr_calc_arbiter: the driver pushes expected results on accept, a monitor pops on output handshake.
module tb_addr_calc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  b = '0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_ptr = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_ptr = '0;
  logic        req1_ready;
  logic        out_valid;
  logic [15:0] out_count;
  logic        out_id;
  logic        out_ready = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  addr_calc_arbiter #(.W(8), .BASE(8'h80), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .b(b),
    .req0_valid(req0_valid), .req0_ptr(req0_ptr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ptr(req1_ptr), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_count(out_count), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] p, input logic [7:0] bb);
    logic [7:0] off;
    off = 8'h80 - p;
    return {8'h00, a} - {8'h00, off} + {8'h00, bb};
  endfunction

  // One cycle: drive at negedge, check readys/out_valid once settled, queue the expected result.
  task automatic cyc(input logic v0, input logic [7:0] p0, input logic v1, input logic [7:0] p1,
                     input logic [7:0] a, input logic [7:0] bb, input logic ordy,
                     input logic e0, input logic e1, input int eov);
    @(negedge clk);
    req0_valid = v0; req0_ptr = p0; req1_valid = v1; req1_ptr = p1;
    address = a; b = bb; out_ready = ordy;
    #1;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (eov >= 0) chk("out_valid", out_valid, eov[0]);
    if (e0) sb.push_back({1'b0, model(a, p0, bb)});
    else if (e1) sb.push_back({1'b1, model(a, p1, bb)});
  endtask

  task automatic idle(input int eov);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, eov);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst req0_ready", req0_ready, 0);
    chk("rst req1_ready", req1_ready, 0);
    chk("rst out_count", out_count, 0);
    chk("rst out_id", out_id, 0);
    sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor, also checks the output is frozen while stalled.
  initial begin : monitor
    logic        prev_stall;
    logic [15:0] prev_count;
    logic        prev_id;
    logic [16:0] e;
    prev_stall = 1'b0; prev_count = '0; prev_id = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall out_valid", out_valid, 1);
          chk("stall out_count", out_count, prev_count);
          chk("stall out_id", out_id, prev_id);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected result", {15'd0, out_id, out_count}, 32'h0);
            chk("scoreboard nonempty", 0, 1);
          end else begin
            e = sb.pop_front();
            chk("out_id", out_id, e[16]);
            chk("out_count", out_count, e[15:0]);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_count = out_count;
        prev_id    = out_id;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    #1;
    chk("init out_valid", out_valid, 0);
    chk("init busy", busy, 0);
    chk("init out_count", out_count, 0);
    chk("init out_id", out_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single accept, result two edges later
    cyc(1'b1, 8'h20, 1'b0, 8'h00, 8'h10, 8'h05, 1'b1, 1'b1, 1'b0, 0);
    idle(0);
    chk("T1 busy s1", busy, 1);
    idle(1);
    chk("T1 count", out_count, 16'hFFB5);
    chk("T1 id", out_id, 0);
    idle(0);

    // T2: offset zero and wrap cases back to back
    cyc(1'b1, 8'h80, 1'b0, 8'h00, 8'h90, 8'h10, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 0);
    idle(1);
    chk("T2 count a", out_count, 16'h00A0);
    idle(1);
    chk("T2 count b", out_count, 16'h017E);
    idle(0);
    chk("T2 busy idle", busy, 0);

    // T3: round robin from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h90 + 16 * i), 8'(8'h40 + 3 * i), 8'(i), 1'b1,
          (i % 2) == 0, (i % 2) == 1, (i >= 2) ? 1 : 0);
    idle(1); idle(1); idle(0);

    // T4: four stall cycles, exactly two accepts, then drain
    cyc(1'b1, 8'h05, 1'b1, 8'hC0, 8'h22, 8'h01, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b1, 8'h06, 1'b1, 8'hC1, 8'h23, 8'h02, 1'b0, 1'b0, 1'b1, 0);
    cyc(1'b1, 8'h07, 1'b1, 8'hC2, 8'h24, 8'h03, 1'b0, 1'b0, 1'b0, 1);
    cyc(1'b1, 8'h08, 1'b1, 8'hC3, 8'h25, 8'h04, 1'b0, 1'b0, 1'b0, 1);
    chk("T4 busy stalled", busy, 1);
    cyc(1'b1, 8'h09, 1'b1, 8'hC4, 8'h26, 8'h05, 1'b1, 1'b1, 1'b0, 1);
    cyc(1'b1, 8'h0A, 1'b1, 8'hC5, 8'h27, 8'h06, 1'b1, 1'b0, 1'b1, 1);
    idle(1); idle(1); idle(0);

    // T5: reset with both stages full; first grant afterwards is req0
    cyc(1'b1, 8'h11, 1'b1, 8'hE1, 8'h50, 8'h07, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 8'h12, 1'b1, 8'hE2, 8'h51, 8'h08, 1'b1, 1'b0, 1'b1, 0);
    cyc(1'b1, 8'h13, 1'b1, 8'hE3, 8'h52, 8'h09, 1'b1, 1'b1, 1'b0, 1);
    do_reset();
    cyc(1'b1, 8'h14, 1'b1, 8'hE4, 8'h53, 8'h0A, 1'b1, 1'b1, 1'b0, 0);
    idle(0); idle(1); idle(0);

    // T6: lone req1 streams with no bubbles
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 8'h00, 1'b1, 8'(8'h70 + i), 8'(8'h31 * i), 8'(8'hF0 + i), 1'b1,
          1'b0, 1'b1, (i >= 2) ? 1 : 0);
    idle(1); idle(1); idle(0);

    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
